e203_biu_ifetch_icb_slv: RTL and testbench
==========================================

E203_BIU_IFETCH_ICB_SLV -- requirements
Module: e203_biu_ifetch_icb_slv

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, meaning SRAM word-address width (capacity 4*2^RAM_AW bytes).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte base address of the served region.
REQ-003 SHALL have parameter RSP_DP, default 2, meaning response-buffer depth (legal 1..4).
REQ-004 SHALL use one clock and a synchronous active-high reset: clk and rst, with no other clock or reset.
REQ-005 clk  in  1  sole clock, rising-edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 icb_cmd_valid  in  1  fetch command valid.
REQ-008 icb_cmd_ready  out  1  fetch command accepted.
REQ-009 icb_cmd_addr  in  E203_ADDR_SIZE  fetch byte address.
REQ-010 icb_rsp_valid  out  1  response valid.
REQ-011 icb_rsp_ready  in  1  response accepted by initiator.
REQ-012 icb_rsp_err  out  1  response error.
REQ-013 icb_rsp_rdata  out  32  fetched instruction word.
REQ-014 ram_cs  out  1  SRAM read enable; ram_addr  out  RAM_AW  word address; ram_dout  in  32  read data, valid the cycle after ram_cs.

Function
REQ-015 Command handshake SHALL occur in a cycle where icb_cmd_valid & icb_cmd_ready are both 1.
REQ-016 icb_cmd_ready SHALL be 1 iff (buffered count + in-flight flag) < RSP_DP, independent of icb_cmd_valid.
REQ-017 On handshake in cycle N: ram_cs=1, ram_addr=icb_cmd_addr[RAM_AW+1:2] in cycle N; ram_cs=0 in all other cycles.
REQ-018 icb_cmd_addr[1:0] SHALL be ignored; the aligned containing word is returned.
REQ-019 In-flight flag SHALL set on handshake in N and clear in N+1 unless a new handshake occurs in N+1.
REQ-020 Response for command at N SHALL be presented at N+1 directly from ram_dout when buffer empty (bypass); otherwise it is written into the buffer tail.
REQ-021 If the bypassed response is not accepted (icb_rsp_ready=0) in N+1, it SHALL be captured into the buffer the same cycle; data is never lost.
REQ-022 icb_rsp_valid SHALL be 1 when buffer non-empty or a bypass response exists; head entry presented first, strict in-order.
REQ-023 Simultaneous buffer write and head pop SHALL keep count unchanged; pointers wrap modulo RSP_DP.
REQ-024 With icb_rsp_ready held 1, throughput SHALL be one command per cycle, latency one cycle.
REQ-025 Response outputs SHALL remain stable while icb_rsp_valid=1 and icb_rsp_ready=0.
REQ-026 icb_rsp_err SHALL be 0 and icb_rsp_rdata SHALL equal ram_dout of the matching read, except per REQ-030.

Reset
REQ-027 While rst=1 at a clock edge: buffer emptied, pointers zero, in-flight cleared; icb_rsp_valid=0, ram_cs=0, icb_cmd_ready=1 from the following cycle.
REQ-028 Reset asserted mid-operation SHALL discard in-flight and buffered responses; none emitted after reset release.
REQ-029 icb_rsp_err and icb_rsp_rdata SHALL read 0 while icb_rsp_valid=0 after reset.

Configuration
REQ-030 With E203_IFETCH_SLV_RANGE_CHK_EN defined: address outside [BASE_ADDR, BASE_ADDR+4*2^RAM_AW) SHALL be accepted normally, ram_cs held 0, and answered in order with icb_rsp_err=1, icb_rsp_rdata=0.
REQ-031 Without E203_IFETCH_SLV_RANGE_CHK_EN: no range compare; upper address bits ignored; icb_rsp_err constant 0.

Structure
REQ-032 Shared package SHALL hold the response-entry layout (err + 32-bit data = 33 bits) and default BASE_ADDR/RAM_AW constants.
REQ-033 Response buffer SHALL be sub-module e203_ifetch_rsp_fifo (parameterised depth/width, count output); control, bypass and range check stay in top.

Verification
REQ-034 Back-to-back: 4 commands 0x8000_0000..0x8000_000C, rsp_ready=1 -> 4 responses cycles N+1..N+4, rdata = SRAM words 0..3, cmd_ready stays 1.
REQ-035 Backpressure: rsp_ready=0, valid held -> exactly 2 handshakes then cmd_ready=0; release -> 2 responses in order, stable while stalled.
REQ-036 Unaligned: addr 0x8000_0006 -> ram_addr=1, rdata=word 1.
REQ-037 Range (macro on): addr 0x7FFF_FFFC -> ram_cs=0, err=1, rdata=0; preceding/following in-range responses order preserved; macro off -> err=0.
REQ-038 Reset mid-stream: rst=1 with 2 buffered responses -> next cycle rsp_valid=0, cmd_ready=1; no stale response after release.

Source files
------------

// File: rtl/e203_biu_ifetch_icb_slv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e203_biu_ifetch_icb_slv_pkg
// Purpose  : Shared constants and response-entry layout for the ifetch slave.
// Revision : 1.0
// ============================================================================
package e203_biu_ifetch_icb_slv_pkg;

    localparam int                E203_ADDR_SIZE = 32;
    localparam int                DFLT_RAM_AW    = 14;
    localparam logic [31:0]       DFLT_BASE_ADDR = 32'h8000_0000;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_ent_t;

    localparam int RSP_ENT_W = $bits(rsp_ent_t);

endpackage
`default_nettype wire

// File: rtl/e203_biu_ifetch_icb_slv_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : e203_ifetch_rsp_fifo
// Purpose  : Small circular response buffer with occupancy count.
// Revision : 1.0
// ============================================================================
module e203_ifetch_rsp_fifo #(
    parameter  int DP    = 2,
    parameter  int DW    = 33,
    localparam int CNT_W = $clog2(DP + 1),
    localparam int PTR_W = (DP > 1) ? $clog2(DP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [DW-1:0]    i_wdat,
    input  logic             i_pop,
    output logic [DW-1:0]    o_rdat,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_cnt
);

    logic [DW-1:0]    mem_q [DP];
    logic [DW-1:0]    mem_d [DP];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_wdat;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DP - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (i_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DP - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        // Concurrent push and pop leaves occupancy unchanged.
        case ({i_push, i_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_rdat  = mem_q[rd_ptr_q];
    assign o_empty = (cnt_q == '0);
    assign o_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/e203_biu_ifetch_icb_slv.sv
`default_nettype none
// ============================================================================
// Module   : e203_biu_ifetch_icb_slv
// Purpose  : ICB instruction-fetch slave onto a 1-cycle-latency SRAM, with
//            response bypass and buffering. Optional address range check
//            enabled by E203_IFETCH_SLV_RANGE_CHK_EN.
// Revision : 1.0
// ============================================================================
module e203_biu_ifetch_icb_slv
    import e203_biu_ifetch_icb_slv_pkg::*;
#(
    parameter int                        RAM_AW    = DFLT_RAM_AW,
    parameter logic [E203_ADDR_SIZE-1:0] BASE_ADDR = DFLT_BASE_ADDR,
    parameter int                        RSP_DP    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      icb_cmd_valid,
    output logic                      icb_cmd_ready,
    input  logic [E203_ADDR_SIZE-1:0] icb_cmd_addr,
    output logic                      icb_rsp_valid,
    input  logic                      icb_rsp_ready,
    output logic                      icb_rsp_err,
    output logic [31:0]               icb_rsp_rdata,
    output logic                      ram_cs,
    output logic [RAM_AW-1:0]         ram_addr,
    input  logic [31:0]               ram_dout
);

    localparam int CNT_W = $clog2(RSP_DP + 1);
    localparam int OCC_W = CNT_W + 1;

    logic             w_cmd_hs;
    logic             w_addr_ok;
    logic             w_inflight_err;
    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] w_occ;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic             w_fifo_empty;
    logic             w_fifo_push;
    logic             w_fifo_pop;
    rsp_ent_t         w_byp_ent;
    rsp_ent_t         w_head_ent;
    rsp_ent_t         w_rsp_ent;
    logic             w_unused_addr;

    // Reserve a buffer slot for every outstanding read before accepting more.
    assign w_occ         = OCC_W'(w_fifo_cnt) + OCC_W'(inflight_q);
    assign icb_cmd_ready = (w_occ < OCC_W'(RSP_DP));
    assign w_cmd_hs      = icb_cmd_valid & icb_cmd_ready;

`ifdef E203_IFETCH_SLV_RANGE_CHK_EN
    localparam logic [E203_ADDR_SIZE:0] REGION_BYTES =
        (E203_ADDR_SIZE + 1)'(1) << (RAM_AW + 2);

    logic [E203_ADDR_SIZE:0] w_addr_off;
    logic                    inflight_err_q, inflight_err_d;

    // Below-base addresses wrap to a huge offset and fail the compare.
    assign w_addr_off     = {1'b0, icb_cmd_addr} - {1'b0, BASE_ADDR};
    assign w_addr_ok      = (w_addr_off < REGION_BYTES);
    assign inflight_err_d = w_cmd_hs & ~w_addr_ok;
    assign w_inflight_err = inflight_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_err_q <= 1'b0;
        end else begin
            inflight_err_q <= inflight_err_d;
        end
    end
`else
    assign w_addr_ok      = 1'b1;
    assign w_inflight_err = 1'b0;
`endif

    assign w_unused_addr = ^{icb_cmd_addr[E203_ADDR_SIZE-1:RAM_AW+2], icb_cmd_addr[1:0]};

    assign ram_cs   = w_cmd_hs & w_addr_ok;
    assign ram_addr = icb_cmd_addr[RAM_AW+1:2];

    assign inflight_d = w_cmd_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Fresh SRAM data; forced to zero when idle so outputs read 0.
    always_comb begin
        w_byp_ent = '0;
        if (inflight_q) begin
            w_byp_ent.err  = w_inflight_err;
            w_byp_ent.data = w_inflight_err ? 32'h0 : ram_dout;
        end
    end

    // Bypass only when buffer is empty and the initiator takes it now.
    assign w_fifo_push = inflight_q & ~(w_fifo_empty & icb_rsp_ready);
    assign w_fifo_pop  = ~w_fifo_empty & icb_rsp_ready;

    e203_ifetch_rsp_fifo #(
        .DP (RSP_DP),
        .DW (RSP_ENT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_wdat  (w_byp_ent),
        .i_pop   (w_fifo_pop),
        .o_rdat  (w_head_ent),
        .o_empty (w_fifo_empty),
        .o_cnt   (w_fifo_cnt)
    );

    assign w_rsp_ent     = w_fifo_empty ? w_byp_ent : w_head_ent;
    assign icb_rsp_valid = ~w_fifo_empty | inflight_q;
    assign icb_rsp_err   = w_rsp_ent.err;
    assign icb_rsp_rdata = w_rsp_ent.data;

endmodule
`default_nettype wire

// File: tb/tb_e203_biu_ifetch_icb_slv.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_biu_ifetch_icb_slv
// Purpose  : Directed table-driven bench for the ifetch ICB slave.
// Revision : 1.0
// ============================================================================
module tb_e203_biu_ifetch_icb_slv;

`ifdef E203_IFETCH_SLV_RANGE_CHK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        ram_cs;
    logic [13:0] ram_addr;
    logic [31:0] ram_dout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_biu_ifetch_icb_slv dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata),
        .ram_cs        (ram_cs),
        .ram_addr      (ram_addr),
        .ram_dout      (ram_dout)
    );

    // SRAM model: word a holds 0xC0DE_xxxx with xxxx = a; garbage when not read.
    always @(posedge clk) begin
        ram_dout <= ram_cs ? {16'hC0DE, 2'b00, ram_addr} : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic        rr;
        logic        rdy;
        logic        cs;
        logic [13:0] ra;
        logic        rv;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [31:0] a, input logic rr,
                       input logic rdy, input logic cs, input logic [13:0] ra,
                       input logic rv, input logic err, input logic [31:0] rd);
        vec_t t;
        t.v = v; t.a = a; t.rr = rr; t.rdy = rdy; t.cs = cs; t.ra = ra;
        t.rv = rv; t.err = err; t.rd = rd;
        vecs.push_back(t);
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic rr, input logic r);
        @(negedge clk);
        icb_cmd_valid = v;
        icb_cmd_addr  = a;
        icb_rsp_ready = rr;
        rst           = r;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int  hs;
    logic stalled;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; icb_cmd_valid = 1'b0; icb_cmd_addr = '0; icb_rsp_ready = 1'b1;

        //   v  addr           rr  rdy cs         ra        rv err  rdata
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);          // reset state
        add(1, 32'h8000_0000,  1,  1,  1,         14'h0,    0, 0,  32'h0);          // back-to-back
        add(1, 32'h8000_0004,  1,  1,  1,         14'h1,    1, 0,  32'hC0DE_0000);
        add(1, 32'h8000_0008,  1,  1,  1,         14'h2,    1, 0,  32'hC0DE_0001);
        add(1, 32'h8000_000C,  1,  1,  1,         14'h3,    1, 0,  32'hC0DE_0002);
        add(0, 32'h0,          1,  1,  0,         14'h0,    1, 0,  32'hC0DE_0003);
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);
        add(1, 32'h8000_0006,  1,  1,  1,         14'h1,    0, 0,  32'h0);          // unaligned
        add(0, 32'h0,          1,  1,  0,         14'h0,    1, 0,  32'hC0DE_0001);
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);
        add(1, 32'h8000_0010,  1,  1,  1,         14'h4,    0, 0,  32'h0);          // below-base
        add(1, 32'h7FFF_FFFC,  1,  1,  !RC,       14'h3FFF, 1, 0,  32'hC0DE_0004);
        add(1, 32'h8000_0014,  1,  1,  1,         14'h5,    1, RC, RC ? 32'h0 : 32'hC0DE_3FFF);
        add(0, 32'h0,          1,  1,  0,         14'h0,    1, 0,  32'hC0DE_0005);
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);
        add(1, 32'h8000_FFFC,  1,  1,  1,         14'h3FFF, 0, 0,  32'h0);          // top edge
        add(1, 32'h8001_0000,  1,  1,  !RC,       14'h0,    1, 0,  32'hC0DE_3FFF);
        add(0, 32'h0,          1,  1,  0,         14'h0,    1, RC, RC ? 32'h0 : 32'hC0DE_0000);
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);
        add(1, 32'h8000_0020,  0,  1,  1,         14'h8,    0, 0,  32'h0);          // backpressure
        add(1, 32'h8000_0024,  0,  1,  1,         14'h9,    1, 0,  32'hC0DE_0008);
        add(1, 32'h8000_0028,  0,  0,  0,         14'h0,    1, 0,  32'hC0DE_0008);
        add(1, 32'h8000_0028,  0,  0,  0,         14'h0,    1, 0,  32'hC0DE_0008);
        add(1, 32'h8000_0028,  1,  0,  0,         14'h0,    1, 0,  32'hC0DE_0008);
        add(0, 32'h0,          1,  1,  0,         14'h0,    1, 0,  32'hC0DE_0009);
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);
        add(1, 32'h8000_0030,  0,  1,  1,         14'hC,    0, 0,  32'h0);          // push+pop, wrap
        add(1, 32'h8000_0034,  0,  1,  1,         14'hD,    1, 0,  32'hC0DE_000C);
        add(0, 32'h0,          1,  0,  0,         14'h0,    1, 0,  32'hC0DE_000C);
        add(0, 32'h0,          1,  1,  0,         14'h0,    1, 0,  32'hC0DE_000D);
        add(0, 32'h0,          1,  1,  0,         14'h0,    0, 0,  32'h0);

        step(0, 32'h0, 1, 1);
        step(0, 32'h0, 1, 1);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].a, vecs[i].rr, 1'b0);
            chk($sformatf("v%0d_cmd_ready", i), 32'(icb_cmd_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_ram_cs", i),    32'(ram_cs),        32'(vecs[i].cs));
            if (vecs[i].cs)
                chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].ra));
            chk($sformatf("v%0d_rsp_valid", i), 32'(icb_rsp_valid), 32'(vecs[i].rv));
            chk($sformatf("v%0d_rsp_err", i),   32'(icb_rsp_err),   32'(vecs[i].err));
            chk($sformatf("v%0d_rsp_rdata", i), icb_rsp_rdata,      vecs[i].rd);
        end

        // Hold valid with no response ready: exactly two commands accepted.
        hs = 0;
        stalled = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1, 32'h8000_0040, 0, 0);
            if (!icb_cmd_ready) begin
                stalled = 1'b1;
                break;
            end
            hs++;
        end
        chk("bp_stall_reached", 32'(stalled), 32'd1);
        chk("bp_handshakes",    32'(hs),      32'd2);
        chk("bp_ram_cs_off",    32'(ram_cs),  32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 0);
            chk($sformatf("stall%0d_valid", i), 32'(icb_rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", i), icb_rsp_rdata,      32'hC0DE_0010);
            chk($sformatf("stall%0d_ready", i), 32'(icb_cmd_ready), 32'd0);
        end

        // Reset with two buffered responses discards them.
        step(0, 32'h0, 0, 1);
        step(0, 32'h0, 1, 0);
        chk("rst_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        chk("rst_rsp_rdata", icb_rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(icb_rsp_err),   32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 1, 0);
            chk($sformatf("post_rst%0d_valid", i), 32'(icb_rsp_valid), 32'd0);
        end

        // One more transaction after reset to confirm normal operation.
        step(1, 32'h8000_0044, 1, 0);
        chk("post_rst_cs",   32'(ram_cs),   32'd1);
        chk("post_rst_addr", 32'(ram_addr), 32'h11);
        step(0, 32'h0, 1, 0);
        chk("post_rst_rsp",  icb_rsp_rdata, 32'hC0DE_0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
